ripple_count_monitor: RTL and testbench
=======================================

// Module: ripple_count_monitor
// PURPOSE
//  Downstream consumer of the 4-bit asynchronous (ripple) down counter. Synchronises the
//  counter's outputs into clk and filters out ripple transients. Tracks the decrement
//  sequence and flags wrap-around (0 -> F), source resets and illegal jumps.
//  Provides a clean registered count plus an extended wrap count to downstream logic.
// PARAMETERS
//  SYNC_STAGES  2     synchroniser flops per bit (min 2)
//  STABLE_CYC   2     consecutive identical synced samples required to accept a value (min 1)
//  WRAP_W       8     width of wrap_count
//  SRC_RST_VAL  4'h0  value the source counter takes on its own reset
// PORTS
//  clk          in   1       sampling clock
//  reset        in   1       synchronous, active-low reset
//  count_in     in   4       ripple counter output, asynchronous to clk
//  clr          in   1       sync clear: wrap_count<=0, seq_err<=0, FSM->INIT
//  cnt_stable   out  4       last accepted (filtered) count
//  cnt_valid    out  1       high once a first value has been accepted
//  wrap_pulse   out  1       1-cycle pulse on accepted 0 -> F transition
//  src_rst_pulse out 1       1-cycle pulse on accepted jump to SRC_RST_VAL (non-decrement)
//  wrap_count   out  WRAP_W  number of counted wraps, saturating at all-ones
//  seq_err      out  1       sticky: illegal transition seen
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all sync/filter flops 0, all outputs 0, FSM=INIT.
//  - Filter: synced value s; run counter restarts when s changes; value accepted when held
//    STABLE_CYC cycles and != cnt_stable (or FSM==INIT). Input latency: a count_in value held
//    constant appears on cnt_stable exactly SYNC_STAGES+STABLE_CYC clk edges later (4 default).
//  - Shorter transients never reach cnt_stable. All pulses coincide with cnt_stable update.
//  - FSM states INIT, TRACK, ERR. Decision uses p = old cnt_stable, v = accepted value:
//    INIT : first accept -> cnt_valid<=1, TRACK; no pulse, no error.
//    TRACK: v==p-1 (mod 16) -> legal; if p==0 && v==F also wrap_pulse, wrap_count+1 (sat).
//           else v==SRC_RST_VAL -> src_rst_pulse, stay TRACK.
//           else -> seq_err<=1, ERR.
//    ERR  : cnt_stable keeps updating; no wrap counting, no pulses; exit only via clr/reset.
//  - clr (reset high): wrap_count<=0, seq_err<=0, cnt_valid<=0, FSM->INIT the next cycle.
//    An accept in the same cycle as clr is discarded; cnt_stable is held.
//  - Reset wins over clr; clr wins over any accept.
//  - wrap_count at 2^WRAP_W-1 stays there; wrap_pulse still fires.
//  - Source counter must hold each value >= SYNC_STAGES+STABLE_CYC+1 clk cycles. Faster
//    sources produce seq_err by design.
// STRUCTURE
//  - Package ripple_mon_pkg: FSM state encoding (INIT/TRACK/ERR, 2 bits), CNT_W=4,
//    function dec4(v) = v-1 mod 16.
//  - Sub-module sync_filter: SYNC_STAGES synchroniser + STABLE_CYC run filter.
//    Outputs an accept strobe and value.
//  - Top holds the FSM, compare logic, wrap_count and output registers.
// TESTING
//  1 reset=0 3 cycles, count_in=9 -> all outputs 0, FSM INIT; release -> cnt_stable=9,
//    cnt_valid=1 exactly 4 cycles after release.
//  2 count_in 3,2,1,0,F,E each held 8 cycles -> one wrap_pulse, aligned with cnt_stable 0->F;
//    wrap_count=1, seq_err=0.
//  3 hold 8; 1-cycle glitches 0 then C (ripple transient); then 7 held -> cnt_stable 8->7
//    directly, seq_err=0.
//  4 stable 6 then 0 (source reset) -> src_rst_pulse once, no wrap_pulse, seq_err=0, TRACK.
//  5 stable 9 then 4 -> seq_err=1, ERR. Then 0->F -> no wrap_pulse, wrap_count unchanged.
//    clr 1 cycle -> seq_err=0, wrap_count=0, cnt_valid=0, next accept re-enters TRACK.
//  6 WRAP_W=3, 9 full down-count cycles -> wrap_count saturates at 7, 9 wrap_pulses.

Source files
------------

// File: rtl/ripple_mon_pkg.sv
// Shared definitions for the ripple counter monitor: count width,
// FSM state encoding and the modulo-16 decrement helper.
package ripple_mon_pkg;

    localparam int CNT_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_INIT  = 2'd0;
    localparam state_t ST_TRACK = 2'd1;
    localparam state_t ST_ERR   = 2'd2;

    // Next value of a 4-bit down counter (wraps 0 -> F).
    function automatic logic [CNT_W-1:0] dec4(input logic [CNT_W-1:0] v);
        return v - 4'd1;
    endfunction

endpackage

// File: rtl/sync_filter.sv
// Brings the asynchronous ripple count into clk and rejects ripple
// transients: 'hit' is high while the synced value has been seen on
// STABLE_CYC consecutive samples; 'value' is that synced value.
module sync_filter
    import ripple_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count_in,
    output logic             hit,
    output logic [CNT_W-1:0] value
);

    localparam int RUN_W = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYC);

    logic [CNT_W-1:0]       sync_q [SYNC_STAGES];
    // Marks which synchroniser stages hold a real sample rather than reset fill,
    // so the zeros loaded by reset are never mistaken for a stable input.
    logic [SYNC_STAGES-1:0] fill_q;
    logic [CNT_W-1:0]       last_q;
    logic [RUN_W-1:0]       run_q;

    logic [CNT_W-1:0] s;
    logic             s_ok;
    logic [RUN_W-1:0] held;

    assign s     = sync_q[SYNC_STAGES-1];
    assign s_ok  = fill_q[SYNC_STAGES-1];
    assign value = s;
    assign hit   = (held == RUN_MAX);

    // Number of consecutive identical samples including the current one (saturating).
    always_comb begin
        held = '0;
        if (!s_ok) begin
            held = '0;
        end else if ((s == last_q) && (run_q != '0)) begin
            held = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
        end else begin
            held = RUN_W'(1);
        end
    end

    // Synchroniser chain plus run-length history.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            fill_q <= '0;
            last_q <= '0;
            run_q  <= '0;
        end else begin
            sync_q[0] <= count_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            last_q <= s;
            run_q  <= held;
        end
    end

endmodule

// File: rtl/ripple_count_monitor.sv
// Consumer of a 4-bit ripple down counter: filters the count, follows the
// decrement sequence, counts wraps and flags source resets / illegal jumps.
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter int               STABLE_CYC  = 2,
    parameter int               WRAP_W      = 8,
    parameter logic [CNT_W-1:0] SRC_RST_VAL = 4'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              clr,
    output logic [CNT_W-1:0]  cnt_stable,
    output logic              cnt_valid,
    output logic              wrap_pulse,
    output logic              src_rst_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              seq_err,
    output state_t            fsm_state
);

    logic             hit;
    logic [CNT_W-1:0] value;
    logic             accept;
    state_t           state;

    sync_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .count_in(count_in),
        .hit     (hit),
        .value   (value)
    );

    // A stable value is taken when it differs from the current one; in INIT
    // even a repeat of the held value counts as the first observation.
    assign accept    = hit && ((state == ST_INIT) || (value != cnt_stable));
    assign fsm_state = state;

    // Tracking FSM, wrap counter and all output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_INIT;
            cnt_stable    <= '0;
            cnt_valid     <= 1'b0;
            wrap_pulse    <= 1'b0;
            src_rst_pulse <= 1'b0;
            wrap_count    <= '0;
            seq_err       <= 1'b0;
        end else begin
            wrap_pulse    <= 1'b0;
            src_rst_pulse <= 1'b0;
            if (clr) begin
                wrap_count <= '0;
                seq_err    <= 1'b0;
                cnt_valid  <= 1'b0;
                state      <= ST_INIT;
            end else if (accept) begin
                cnt_stable <= value;
                case (state)
                    ST_INIT: begin
                        cnt_valid <= 1'b1;
                        state     <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (value == dec4(cnt_stable)) begin
                            if (cnt_stable == '0) begin
                                wrap_pulse <= 1'b1;
                                if (wrap_count != '1) wrap_count <= wrap_count + WRAP_W'(1);
                            end
                        end else if (value == SRC_RST_VAL) begin
                            src_rst_pulse <= 1'b1;
                        end else begin
                            seq_err <= 1'b1;
                            state   <= ST_ERR;
                        end
                    end
                    default: begin
                        state <= ST_ERR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: reset/latency, decrement with
// wrap, glitch rejection, source reset, illegal jump + clr, and saturation
// of a narrow wrap counter on a second instance.
module tb_ripple_count_monitor;
    import ripple_mon_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] count_in = 4'h0;

    logic [3:0] cnt_stable;
    logic       cnt_valid, wrap_pulse, src_rst_pulse, seq_err;
    logic [7:0] wrap_count;
    state_t     fsm_state;

    logic [3:0] n_cnt_stable;
    logic       n_cnt_valid, n_wrap_pulse, n_src_rst_pulse, n_seq_err;
    logic [2:0] n_wrap_count;
    state_t     n_fsm_state;

    ripple_count_monitor #(.WRAP_W(8)) dut (
        .clk(clk), .reset(reset), .count_in(count_in), .clr(clr),
        .cnt_stable(cnt_stable), .cnt_valid(cnt_valid), .wrap_pulse(wrap_pulse),
        .src_rst_pulse(src_rst_pulse), .wrap_count(wrap_count), .seq_err(seq_err),
        .fsm_state(fsm_state)
    );

    ripple_count_monitor #(.WRAP_W(3)) dut_narrow (
        .clk(clk), .reset(reset), .count_in(count_in), .clr(clr),
        .cnt_stable(n_cnt_stable), .cnt_valid(n_cnt_valid), .wrap_pulse(n_wrap_pulse),
        .src_rst_pulse(n_src_rst_pulse), .wrap_count(n_wrap_count), .seq_err(n_seq_err),
        .fsm_state(n_fsm_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // scoreboard state
    int         wrap_seen = 0;
    int         wrap_seen_n = 0;
    int         srst_seen = 0;
    int         align_bad = 0;
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    logic [3:0] prev_stable = 4'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor, sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (wrap_pulse) begin
            wrap_seen++;
            if (cnt_stable != 4'hF) align_bad++;
        end
        if (n_wrap_pulse) wrap_seen_n++;
        if (src_rst_pulse) srst_seen++;
        if (cnt_stable != prev_stable) begin
            obs_q.push_back(cnt_stable);
            prev_stable = cnt_stable;
        end
    end

    // driver: hold a count value for n cycles (changes on the falling edge)
    task automatic hold(input logic [3:0] v, input int n);
        count_in = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int         base, base_n, base_s, c0;
        logic [3:0] v;

        @(negedge clk);
        // 1: reset state and first-accept latency
        reset = 1'b0;
        count_in = 4'h9;
        repeat (3) @(negedge clk);
        check_val("rst_cnt_stable", 32'(cnt_stable), 32'h0);
        check_val("rst_cnt_valid", 32'(cnt_valid), 32'h0);
        check_val("rst_wrap_count", 32'(wrap_count), 32'h0);
        check_val("rst_seq_err", 32'(seq_err), 32'h0);
        check_val("rst_pulses", 32'({wrap_pulse, src_rst_pulse}), 32'h0);
        check_val("rst_state", 32'(fsm_state), 32'(ST_INIT));
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_val("lat_valid_early", 32'(cnt_valid), 32'h0);
        @(negedge clk);
        check_val("lat_valid", 32'(cnt_valid), 32'h1);
        check_val("lat_cnt_stable", 32'(cnt_stable), 32'h9);
        check_val("lat_state", 32'(fsm_state), 32'(ST_TRACK));

        // 2: decrement 8..0,F,E with one wrap
        obs_q.delete();
        exp_q.delete();
        base = wrap_seen;
        v = 4'h8;
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(v);
            hold(v, 8);
            v = v - 4'd1;
        end
        check_val("dec_seq_len", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_val("dec_seq_val", 32'(obs_q[i]), 32'(exp_q[i]));
        check_val("dec_wrap_pulses", 32'(wrap_seen - base), 32'd1);
        check_val("dec_wrap_count", 32'(wrap_count), 32'd1);
        check_val("dec_seq_err", 32'(seq_err), 32'h0);
        check_val("dec_wrap_align", 32'(align_bad), 32'd0);

        // 3: glitches 0 and C between 8 and 7
        v = 4'hD;
        for (int i = 0; i < 6; i++) begin
            hold(v, 8);
            v = v - 4'd1;
        end
        c0 = obs_q.size();
        hold(4'h0, 1);
        hold(4'hC, 1);
        hold(4'h7, 8);
        check_val("glitch_updates", 32'(obs_q.size() - c0), 32'd1);
        check_val("glitch_cnt_stable", 32'(cnt_stable), 32'h7);
        check_val("glitch_seq_err", 32'(seq_err), 32'h0);

        // 4: source reset 6 -> 0
        hold(4'h6, 8);
        base = wrap_seen;
        base_s = srst_seen;
        hold(4'h0, 8);
        check_val("srst_pulses", 32'(srst_seen - base_s), 32'd1);
        check_val("srst_no_wrap", 32'(wrap_seen - base), 32'd0);
        check_val("srst_seq_err", 32'(seq_err), 32'h0);
        check_val("srst_state", 32'(fsm_state), 32'(ST_TRACK));
        check_val("srst_cnt_stable", 32'(cnt_stable), 32'h0);

        // 5: illegal jump 9 -> 4, ERR behaviour, clr
        v = 4'hF;
        for (int i = 0; i < 7; i++) begin
            hold(v, 8);
            v = v - 4'd1;
        end
        check_val("err_pre_wrap_count", 32'(wrap_count), 32'd2);
        hold(4'h4, 8);
        check_val("err_seq_err", 32'(seq_err), 32'h1);
        check_val("err_state", 32'(fsm_state), 32'(ST_ERR));
        check_val("err_cnt_stable", 32'(cnt_stable), 32'h4);
        base = wrap_seen;
        hold(4'h0, 8);
        hold(4'hF, 8);
        check_val("err_no_wrap_pulse", 32'(wrap_seen - base), 32'd0);
        check_val("err_wrap_count", 32'(wrap_count), 32'd2);
        check_val("err_cnt_follow", 32'(cnt_stable), 32'hF);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_val("clr_seq_err", 32'(seq_err), 32'h0);
        check_val("clr_wrap_count", 32'(wrap_count), 32'd0);
        check_val("clr_cnt_valid", 32'(cnt_valid), 32'h0);
        check_val("clr_state", 32'(fsm_state), 32'(ST_INIT));
        check_val("clr_cnt_held", 32'(cnt_stable), 32'hF);
        @(negedge clk);
        check_val("clr_reaccept_valid", 32'(cnt_valid), 32'h1);
        check_val("clr_reaccept_state", 32'(fsm_state), 32'(ST_TRACK));

        // 6: nine full down-count cycles, narrow counter saturates
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        hold(4'h0, 8);
        base = wrap_seen;
        base_n = wrap_seen_n;
        for (int k = 0; k < 9; k++) begin
            v = 4'hF;
            for (int i = 0; i < 16; i++) begin
                hold(v, 6);
                v = v - 4'd1;
            end
        end
        check_val("sat_pulses_wide", 32'(wrap_seen - base), 32'd9);
        check_val("sat_pulses_narrow", 32'(wrap_seen_n - base_n), 32'd9);
        check_val("sat_count_wide", 32'(wrap_count), 32'd9);
        check_val("sat_count_narrow", 32'(n_wrap_count), 32'd7);
        check_val("sat_seq_err", 32'({seq_err, n_seq_err}), 32'h0);
        check_val("sat_wrap_align", 32'(align_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
